csa_multiword_seq: RTL
======================

Name: csa_multiword_seq

Overview:
- Multi-precision add/subtract sequencer for one external WIDE-bit carry_select_adder instance.
- Accepts two WORDS*WIDE-bit operands and feeds one WIDE-bit slice per cycle to the adder, LSB word first.
- Chains each slice's carry-out into the next slice's carry-in.
- Assembles the full result, carry-out and signed overflow, then pulses done.

Parameters:
- WIDE, 4, slice width; must equal the attached adder width.
- WORDS, 4, number of slices per operand (>=2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- sub  in  1  0 = A+B+cin, 1 = A-B (cin ignored); sampled with start.
- cin  in  1  carry-in for add mode; sampled with start.
- op_a  in  WIDE*WORDS  operand A; sampled with start.
- op_b  in  WIDE*WORDS  operand B; sampled with start.
- ready  out  1  high only in IDLE.
- add_a  out  WIDE  slice of A to adder.
- add_b  out  WIDE  slice of B (inverted if sub) to adder.
- add_cin  out  1  carry to adder.
- add_sum  in  WIDE  adder sum (combinational from add_a/add_b/add_cin).
- add_cout  in  1  adder carry-out.
- result  out  WIDE*WORDS  assembled result; holds until next accepted start or reset.
- cout  out  1  final carry; in sub mode, 1 = no borrow.
- ovf  out  1  two's-complement overflow of full-width operation.
- done  out  1  one-cycle pulse when result/cout/ovf are valid.

Behaviour:
- Reset (sync, active-high) clears everything; takes priority over all other activity:
  - state=IDLE, idx=0, carry=0.
  - Internal operand registers cleared.
  - result=0, cout=0, ovf=0, done=0.
  - Back to IDLE with no done pulse from any state, including mid-RUN.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1; add_a=0, add_b=0, add_cin=0.
  - On start=1, at the clock edge:
    - a_reg<=op_a.
    - b_reg<=sub ? ~op_b : op_b.
    - carry<=sub ? 1 : cin.
    - idx<=0; result<=0.
    - Go to RUN.
  - start=0 means stay in IDLE.
- RUN:
  - ready=0.
  - add_a=a_reg[idx*WIDE +: WIDE], add_b=b_reg[idx*WIDE +: WIDE], add_cin=carry.
  - Each edge: result[idx*WIDE +: WIDE]<=add_sum; carry<=add_cout; idx<=idx+1.
  - On the edge where idx==WORDS-1:
    - cout<=add_cout.
    - ovf<=(a_reg MSB == b_reg MSB) && (add_sum MSB != a_reg MSB), using b_reg after inversion.
    - Go to DONE.
- DONE:
  - done=1 for exactly this cycle; ready=0; adder drive outputs=0.
  - Next edge returns to IDLE.
- start outside IDLE is ignored; it is neither queued nor latched.
- Operand inputs are don't-care except in the accepting cycle.
- Latency: start accepted at edge T; RUN occupies WORDS cycles; done is high in the cycle after edge T+WORDS.
  - WORDS=4 gives 5 cycles from accept to done, and 6 cycles between successive accepts.
- Arithmetic:
  - Modulo 2^(WIDE*WORDS); word 0 is least significant.
  - Carry propagates strictly through the carry register, one slice per cycle.
  - ovf applies to both add and sub.
- Outputs result, cout and ovf are registered and stable from the done cycle until the next accepted start.

Test Plan (WIDE=4, WORDS=4):
1. Hold reset 2 cycles, then release -> ready=1, done=0, result=16'h0000, cout=0, ovf=0; adder drive outputs 0.
2. start, op_a=16'h0001, op_b=16'h0001, sub=0, cin=0 -> done pulses exactly 5 cycles after accept; result=16'h0002, cout=0, ovf=0. Add_cin per RUN cycle must be 0,0,0,0.
3. op_a=16'hFFFF, op_b=16'h0001, cin=0 -> result=16'h0000, cout=1, ovf=0. Add_cin per RUN cycle must be 0,1,1,1 (full carry ripple across all words).
4. Subtract and signed-overflow cases:
   - sub=1, op_a=16'h0005, op_b=16'h0007 -> result=16'hFFFE, cout=0 (borrow), ovf=0.
   - sub=1, op_a=16'h8000, op_b=16'h0001 -> result=16'h7FFF, cout=1, ovf=1.
   - add, op_a=16'h7FFF, op_b=16'h0001 -> result=16'h8000, ovf=1.
5. start held high continuously with changing operands -> only the operands present in IDLE-accept cycles are used; ready/done alternate with a 6-cycle period; no start is accepted during RUN or DONE.
6. reset asserted in the 2nd RUN cycle of op_a=16'h1234 + op_b=16'h1111 -> next cycle IDLE, result=16'h0000, no done pulse. A subsequent start completes correctly with result=16'h2345.

Source files
------------

// File: rtl/csa_multiword_seq.sv
// Multi-precision add/subtract sequencer. It drives one external WIDE-bit adder,
// one slice per cycle, starting with the LSB word, and chains the carry through a register.
module csa_multiword_seq #(
  parameter int WIDE  = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  sub_i,
  input  logic                  cin_i,
  input  logic [WIDE*WORDS-1:0] op_a_i,
  input  logic [WIDE*WORDS-1:0] op_b_i,
  output logic                  ready_o,
  output logic [WIDE-1:0]       add_a_o,
  output logic [WIDE-1:0]       add_b_o,
  output logic                  add_cin_o,
  input  logic [WIDE-1:0]       add_sum_i,
  input  logic                  add_cout_i,
  output logic [WIDE*WORDS-1:0] result_o,
  output logic                  cout_o,
  output logic                  ovf_o,
  output logic                  done_o
);

  localparam int N  = WIDE * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [N-1:0]  a_q, b_q, result_q;
  logic [IW-1:0] idx_q;
  logic          carry_q, cout_q, ovf_q, done_q, ready_q;

  // The adder sees live operand slices only while running; it sees zero otherwise.
  always_comb begin
    add_a_o   = '0;
    add_b_o   = '0;
    add_cin_o = 1'b0;
    if (state_q == RUN) begin
      add_a_o   = a_q[idx_q*WIDE +: WIDE];
      add_b_o   = b_q[idx_q*WIDE +: WIDE];
      add_cin_o = carry_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            // Subtraction is A + ~B + 1, so B is inverted once and the carry is forced high.
            a_q      <= op_a_i;
            b_q      <= sub_i ? ~op_b_i : op_b_i;
            carry_q  <= sub_i | cin_i;
            idx_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q[idx_q*WIDE +: WIDE] <= add_sum_i;
          carry_q <= add_cout_i;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            cout_q  <= add_cout_i;
            ovf_q   <= (a_q[N-1] == b_q[N-1]) && (add_sum_i[WIDE-1] != a_q[N-1]);
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;

endmodule
